comp_mult_wrapper: RTL and testbench

COMP_MULT_WRAPPER -- requirements
Module: comp_mult_wrapper

---
 rtl/comp_mult_wrapper.sv | 135 +++++++++++++
 tb/tb_comp_mult_wrapper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/comp_mult_wrapper.sv
// Complex multiplier (x1 + i*y1)*(x2 + i*y2) with valid/ready handshakes.
// NO_MULT lanes share the four partial products over 4/NO_MULT CALC cycles.
module comp_mult_lane #(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0]   a,
  input  logic [DWIDTH-1:0]   b,
  output logic [2*DWIDTH-1:0] p
);
  assign p = a * b;
endmodule

module comp_mult_wrapper #(
  parameter int DWIDTH  = 8,
  parameter int NO_MULT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sw_rst,
  input  logic                      op_val,
  output logic                      op_rdy,
  input  logic [4*DWIDTH-1:0]       op_data,
  output logic                      res_val,
  input  logic                      res_rdy,
  output logic [4*(DWIDTH+1)-1:0]   res_data
);
  localparam int RW = 2*DWIDTH + 2;
  localparam int PW = 2*DWIDTH;
  localparam int NC = 4 / NO_MULT;

  generate
    if (NO_MULT != 1 && NO_MULT != 2 && NO_MULT != 4) begin : g_bad_cfg
      $error("comp_mult_wrapper: NO_MULT must be 1, 2 or 4");
    end
  endgenerate

  typedef struct packed {
    logic [DWIDTH-1:0] x1;
    logic [DWIDTH-1:0] y1;
    logic [DWIDTH-1:0] x2;
    logic [DWIDTH-1:0] y2;
  } ops_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t  state_q, state_d;
  ops_t    ops_q;
  logic [1:0]    cnt_q;
  logic [RW-1:0] acc_x_q, acc_y_q, sum_x, sum_y;
  logic          last_cyc;

  logic [NO_MULT-1:0][1:0]        sel;
  logic [NO_MULT-1:0][DWIDTH-1:0] mul_a, mul_b;
  logic [NO_MULT-1:0][PW-1:0]     prod;

  assign last_cyc = (cnt_q == 2'(NC-1));

  // Product index: 0 x1*x2 (+re), 1 y1*y2 (-re), 2 x1*y2 (+im), 3 y1*x2 (+im)
  generate
    for (genvar j = 0; j < NO_MULT; j++) begin : g_lane
      assign sel[j]   = 2'(int'(cnt_q) * NO_MULT + j);
      assign mul_a[j] = sel[j][0] ? ops_q.y1 : ops_q.x1;
      assign mul_b[j] = (sel[j][1] ^ sel[j][0]) ? ops_q.y2 : ops_q.x2;
      comp_mult_lane #(.DWIDTH(DWIDTH)) u_lane (
        .a (mul_a[j]),
        .b (mul_b[j]),
        .p (prod[j])
      );
    end
  endgenerate

  always_comb begin
    sum_x = acc_x_q;
    sum_y = acc_y_q;
    for (int j = 0; j < NO_MULT; j++) begin
      if (!sel[j][1]) sum_x = sel[j][0] ? sum_x - RW'(prod[j]) : sum_x + RW'(prod[j]);
      else            sum_y = sum_y + RW'(prod[j]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_val)   state_d = CALC;
      CALC:    if (last_cyc) state_d = DONE;
      DONE:    if (res_rdy)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state_q <= IDLE;
    else if (sw_rst) state_q <= IDLE;
    else             state_q <= state_d;
  end

  assign op_rdy  = (state_q == IDLE);
  assign res_val = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q    <= '0;
      cnt_q    <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      res_data <= '0;
    end else if (sw_rst) begin
      ops_q    <= '0;
      cnt_q    <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      res_data <= '0;
    end else begin
      case (state_q)
        IDLE: if (op_val) begin
          ops_q   <= ops_t'(op_data);
          cnt_q   <= '0;
          acc_x_q <= '0;
          acc_y_q <= '0;
        end
        CALC: begin
          if (last_cyc) begin
            res_data <= {sum_x, sum_y};
            cnt_q    <= '0;
          end else begin
            cnt_q    <= cnt_q + 2'd1;
          end
          acc_x_q <= sum_x;
          acc_y_q <= sum_y;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_mult_wrapper.sv
// Bench for comp_mult_wrapper: three instances (NO_MULT 1/2/4) checked each
// cycle against a transaction-level model plus directed literal vectors.
module tb_comp_mult_wrapper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_rst = 1'b0;
  logic        op_val  [3];
  logic        op_rdy  [3];
  logic [31:0] op_data [3];
  logic        res_val [3];
  logic        res_rdy [3];
  logic [35:0] res_data[3];

  int nc[3] = '{4, 2, 1};
  int nvec = 0;
  int nerr = 0;

  bit          inflight[3];
  int          age     [3];
  logic [35:0] expv    [3];
  logic [35:0] last    [3];
  int          acc_cnt [3];

  logic [31:0] vops[6];
  logic [35:0] vexp[6];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      comp_mult_wrapper #(.DWIDTH(8), .NO_MULT(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_rst   (sw_rst),
        .op_val   (op_val[g]),
        .op_rdy   (op_rdy[g]),
        .op_data  (op_data[g]),
        .res_val  (res_val[g]),
        .res_rdy  (res_rdy[g]),
        .res_data (res_data[g])
      );
    end
  endgenerate

  task automatic check(input string name, input int k, input logic [35:0] got, input logic [35:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, got, want, $time);
    end
  endtask

  // Complex product by plain integer arithmetic, truncated to 18-bit fields
  function automatic logic [35:0] model(input logic [31:0] d);
    int x1, y1, x2, y2, xr, yr;
    x1 = int'(d[31:24]); y1 = int'(d[23:16]);
    x2 = int'(d[15:8]);  y2 = int'(d[7:0]);
    xr = x1 * x2 - y1 * y2;
    yr = x1 * y2 + y1 * x2;
    return {xr[17:0], yr[17:0]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin inflight[k] = 0; last[k] = '0; end
      check("op_rdy", k, 36'(op_rdy[k]), 36'(!inflight[k]));
      check("res_val", k, 36'(res_val[k]), 36'(inflight[k] && age[k] >= nc[k]));
      if (inflight[k] && age[k] >= nc[k]) check("res_data", k, res_data[k], expv[k]);
      else                                check("res_hold", k, res_data[k], last[k]);
      if (!rst_n || sw_rst) begin
        inflight[k] = 0; last[k] = '0;
      end else if (!inflight[k]) begin
        if (op_val[k]) begin
          inflight[k] = 1; age[k] = 0; expv[k] = model(op_data[k]); acc_cnt[k]++;
        end
      end else if (age[k] >= nc[k] && res_rdy[k]) begin
        inflight[k] = 0; last[k] = expv[k];
      end else begin
        age[k]++;
      end
    end
  end

  // Starts and ends just after a rising edge.
  task automatic run_vec(input int k, input logic [31:0] ops, input logic [35:0] ex, input int hold);
    int n;
    logic [35:0] held;
    res_rdy[k] = (hold == 0);
    op_data[k] = ops;
    op_val[k]  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!op_rdy[k] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("accept_timeout", k, 36'(n), 36'(0));
    @(posedge clk); #1 op_val[k] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!res_val[k] && n < 12) begin @(negedge clk); n++; end
    check("latency", k, 36'(n), 36'(nc[k]));
    check("vector", k, res_data[k], ex);
    held = res_data[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_val", k, 36'(res_val[k]), 36'(1));
      check("bp_data", k, res_data[k], held);
      check("bp_rdy", k, 36'(op_rdy[k]), 36'(0));
    end
    if (hold > 0) begin
      @(posedge clk); #1 res_rdy[k] = 1'b1;
    end
    @(posedge clk); #1;
    check("post_op_rdy", k, 36'(op_rdy[k]), 36'(1));
    check("post_res_val", k, 36'(res_val[k]), 36'(0));
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int cyc;
    int base[3];
    vops[0] = {8'd2,   8'd3,   8'd4,   8'd2};   vexp[0] = {18'd2, 18'd16};
    vops[1] = {8'd3,   8'd3,   8'd4,   8'd2};   vexp[1] = {18'd6, 18'd18};
    vops[2] = {8'd0,   8'd0,   8'd0,   8'd0};   vexp[2] = {18'd0, 18'd0};
    vops[3] = {8'd255, 8'd255, 8'd255, 8'd255}; vexp[3] = {18'd0, 18'h1FC02};
    vops[4] = {8'd128, 8'd128, 8'd128, 8'd128}; vexp[4] = {18'd0, 18'd32768};
    vops[5] = {8'd100, 8'd101, 8'd102, 8'd103}; vexp[5] = {18'h3FF35, 18'd20602};
    for (int k = 0; k < 3; k++) begin
      op_val[k] = 1'b0; op_data[k] = '0; res_rdy[k] = 1'b0;
      inflight[k] = 0; age[k] = 0; expv[k] = '0; last[k] = '0; acc_cnt[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 3; k++)
      for (int v = 0; v < 6; v++)
        run_vec(k, vops[v], vexp[v], (v == 5) ? 5 : 0);

    // Synchronous reset while instance 0 is mid-CALC
    res_rdy[0] = 1'b1; op_data[0] = vops[5]; op_val[0] = 1'b1;
    @(posedge clk); #1 op_val[0] = 1'b0;
    @(posedge clk); #1 sw_rst = 1'b1;
    @(posedge clk); #1 sw_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("swrst_op_rdy", k, 36'(op_rdy[k]), 36'(1));
      check("swrst_res_val", k, 36'(res_val[k]), 36'(0));
      check("swrst_res_data", k, res_data[k], 36'(0));
    end
    repeat (6) @(posedge clk);
    #1;
    check("swrst_no_result", 0, 36'(res_val[0]), 36'(0));

    run_vec(0, vops[1], vexp[1], 0);
    // Asynchronous reset while instance 0 is mid-CALC, checked before any edge
    op_data[0] = vops[3]; op_val[0] = 1'b1;
    @(posedge clk); #1 op_val[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("hwrst_op_rdy", 0, 36'(op_rdy[0]), 36'(1));
    check("hwrst_res_val", 0, 36'(res_val[0]), 36'(0));
    check("hwrst_res_data", 0, res_data[0], 36'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("hwrst_no_result", 0, 36'(res_val[0]), 36'(0));

    for (int k = 0; k < 3; k++) base[k] = acc_cnt[k];
    cyc = 0;
    while ((acc_cnt[0] - base[0] < 1000 || acc_cnt[1] - base[1] < 1000 ||
            acc_cnt[2] - base[2] < 1000) && cyc < 40000) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        op_val[k]  = 1'($urandom_range(0, 1));
        op_data[k] = {rnd8(), rnd8(), rnd8(), rnd8()};
        res_rdy[k] = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    if (cyc >= 40000) check("random_timeout", 0, 36'(cyc), 36'(0));
    for (int k = 0; k < 3; k++) begin op_val[k] = 1'b0; res_rdy[k] = 1'b1; end
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("drain_idle", k, 36'(op_rdy[k]), 36'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
